// File: rtl/muldiv_pkg.sv
// Shared encodings and operand-classification helpers for the iterative
// RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_FAST
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide on magnitudes, one bit per cycle, with a fast path for divide corners.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int CW = $clog2(XLEN) + 1;

  state_t            state_q;
  logic [2:0]        op_q;
  logic              sign_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN-1:0]   result_q;
  logic              busy_q;
  logic              done_q;

  logic              a_neg, b_neg, b_zero, ovf, take_fast, sign_d;
  logic [XLEN-1:0]   a_abs, b_abs, fast_val, fix_val;
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] mul_step, div_step, prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    a_neg     = a_signed(op) & a[XLEN-1];
    b_neg     = b_signed(op) & b[XLEN-1];
    a_abs     = a_neg ? -a : a;
    b_abs     = b_neg ? -b : b;
    b_zero    = (b == '0);
    // Signed overflow: most-negative dividend over -1.
    ovf       = a_signed(op) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
    take_fast = is_div(op) && (b_zero || ovf);
    if (b_zero) fast_val = op[1] ? a : {XLEN{1'b1}};
    else        fast_val = op[1] ? '0 : a;
    sign_d    = (is_div(op) && op[1]) ? a_neg : (a_neg ^ b_neg);

    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step = {mul_sum, acc_q[XLEN-1:1]};

    // The remainder bit shifted out is kept so divisors above 2^(XLEN-1) work.
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    diff     = rem_sh - {1'b0, opnd_q};
    div_step = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};

    prod = sign_q ? -acc_q : acc_q;
    quo  = sign_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = sign_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:             fix_val = prod[XLEN-1:0];
      OP_DIV, OP_DIVU:    fix_val = quo;
      OP_REM, OP_REMU:    fix_val = rem;
      default:            fix_val = prod[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A start coinciding with done belongs to the finishing op's window.
          if (start && !done_q) begin
            op_q   <= op;
            sign_q <= sign_d;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (take_fast) begin
              acc_q   <= {{XLEN{1'b0}}, fast_val};
              state_q <= S_FAST;
            end else begin
              acc_q   <= {{XLEN{1'b0}}, is_div(op) ? a_abs : b_abs};
              opnd_q  <= is_div(op) ? b_abs : a_abs;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc_q <= is_div(op_q) ? div_step : mul_step;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          result_q <= fix_val;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          result_q <= acc_q[XLEN-1:0];
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = (result_q == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: issued ops push expected result/latency,
// a monitor pops and checks on every done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, zero;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          bcy;
    int          scyc;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'({32'd0, x});
    longint uy = longint'({32'd0, y});
    logic [63:0] p;
    logic ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ov) return x;
        p = sx / sy; return p[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        p = ux / uy; return p[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (ov) return 32'd0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        p = ux % uy; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o < 3'd4) return 1'b0;
    if (y == 0) return 1'b1;
    return (o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: latency, busy duration, result and zero flag per done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0;
      end else begin
        if (busy && done) check("busy_done_overlap", 32'd1, 32'd0);
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            $display("op=%0d a=%h b=%h result=%h exp=%h lat=%0d busy=%0d",
                     e.op, e.a, e.b, result, e.res, cyc - e.scyc, busy_cnt);
            check("result", result, e.res);
            check("zero", {31'd0, zero}, {31'd0, e.res == 32'd0});
            check("latency", 32'(cyc - e.scyc), 32'(e.lat));
            check("busy_cycles", 32'(busy_cnt), 32'(e.bcy));
          end
          busy_cnt = 0;
        end else if (busy) begin
          busy_cnt++;
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
    exp_t e;
    drain();
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    if (push) begin
      e.res  = ref_res(o, x, y);
      e.lat  = is_fast(o, x, y) ? 2 : 34;
      e.bcy  = is_fast(o, x, y) ? 1 : 33;
      e.scyc = cyc;
      e.op = o; e.a = x; e.b = y;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    reset = 1'b0;
    @(negedge clk);

    issue(3'd0, 32'd10, 32'd5, 1'b1);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(3'd5, 32'd10, 32'd5, 1'b1);
    issue(3'd7, 32'd10, 32'd5, 1'b1);
    issue(3'd4, 32'd10, 32'd0, 1'b1);
    issue(3'd7, 32'd10, 32'd0, 1'b1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

    // Start while busy must neither restart nor resample operands.
    issue(3'd0, 32'd7, 32'd6, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;

    // Start during the done cycle must be ignored.
    drain();
    issue(3'd5, 32'd10, 32'd5, 1'b1);
    begin
      int n = 0;
      while (!done && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
    end
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    // Reset during iteration 10 of a DIVU aborts it silently.
    issue(3'd5, 32'hDEAD_BEEF, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_zero", {31'd0, zero}, 32'd1);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd3, 32'd4, 1'b1);

    for (int i = 0; i < 150; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      issue(o, pick(), pick(), 1'b1);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
